// File: rtl/clk_div_cfg_if.sv
// Ratio-request port of the clock divider controller: valid/ready handshake plus
// a one-cycle error pulse for rejected ratios.
interface clk_div_cfg_if #(
    parameter int DIV_W = 8
);
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (output cfg_valid, cfg_div, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_cfg_ctrl.sv
// Controller for a runtime-programmable clock divider: buffers one ratio request and
// applies it only at a period boundary by pulsing the divider's sync reset.
//
// state  | meaning
// IDLE   | divider parked in reset; pending ratio loads immediately
// RUN    | divider running; phase counts 0..div_val-1
// SWITCH | one-cycle reset pulse between periods; pending ratio loads here
module clk_div_cfg_ctrl #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 7,
    parameter int MIN_DIV     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    clk_div_cfg_if.slave     cfg,
    output logic [DIV_W-1:0] div_val,
    output logic             div_rst,
    output logic [DIV_W-1:0] phase,
    output logic             tick,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div_val_n;
    logic [DIV_W-1:0] phase_n;
    logic [DIV_W-1:0] pend_div, pend_div_n;
    logic             pend_vld, pend_vld_n;
    logic             err_q, err_n;
    logic             div_rst_n;
    logic             tick_n;
    logic             accept;
    logic [DIV_W-1:0] div_last;

    assign div_last      = div_val - DIV_W'(1);
    assign cfg.cfg_ready = ~pend_vld;
    assign cfg.cfg_err   = err_q;
    assign busy          = pend_vld | ((state == ST_RUN) & ~en);

    always_comb begin
        state_n    = state;
        div_val_n  = div_val;
        phase_n    = phase;
        pend_div_n = pend_div;
        pend_vld_n = pend_vld;
        accept     = cfg.cfg_valid & ~pend_vld;
        err_n      = accept & (cfg.cfg_div < DIV_W'(MIN_DIV));

        unique case (state)
            ST_IDLE: begin
                phase_n = '0;
                if (pend_vld) begin
                    div_val_n  = pend_div;
                    pend_vld_n = 1'b0;
                end
                if (en) state_n = ST_RUN;
            end
            ST_RUN: begin
                // Decision uses registered pend_vld, so a request landing on the
                // boundary edge waits for the next boundary.
                if (phase == div_last) begin
                    phase_n = '0;
                    if (pend_vld | ~en) state_n = ST_SWITCH;
                end else begin
                    phase_n = phase + DIV_W'(1);
                end
            end
            ST_SWITCH: begin
                phase_n = '0;
                if (pend_vld) begin
                    div_val_n  = pend_div;
                    pend_vld_n = 1'b0;
                end
                state_n = en ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                phase_n = '0;
            end
        endcase

        // accept implies the buffer was empty, so this never collides with a load
        if (accept & ~err_n) begin
            pend_div_n = cfg.cfg_div;
            pend_vld_n = 1'b1;
        end

        div_rst_n = (state_n != ST_RUN);
        tick_n    = (state_n == ST_RUN) & (phase_n == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            div_val  <= DIV_W'(DEFAULT_DIV);
            phase    <= '0;
            pend_div <= '0;
            pend_vld <= 1'b0;
            err_q    <= 1'b0;
            div_rst  <= 1'b1;
            tick     <= 1'b0;
        end else begin
            state    <= state_n;
            div_val  <= div_val_n;
            phase    <= phase_n;
            pend_div <= pend_div_n;
            pend_vld <= pend_vld_n;
            err_q    <= err_n;
            div_rst  <= div_rst_n;
            tick     <= tick_n;
        end
    end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Bench for clk_div_cfg_ctrl: directed scenarios plus a randomized run against a
// period-arithmetic reference model.
module tb_clk_div_cfg_ctrl;
    localparam int DIV_W  = 8;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_SW   = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic [DIV_W-1:0] div_val;
    logic             div_rst;
    logic [DIV_W-1:0] phase;
    logic             tick;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_cfg_if #(.DIV_W(DIV_W)) cif ();

    clk_div_cfg_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(7), .MIN_DIV(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .cfg    (cif),
        .div_val(div_val),
        .div_rst(div_rst),
        .phase  (phase),
        .tick   (tick),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Reference model: phase is the cycle count since RUN entry modulo the ratio.
    int m_mode  = M_IDLE;
    int m_ratio = 7;
    int m_start = 0;
    int m_cyc   = 0;
    bit m_err   = 1'b0;
    int m_pend[$];

    function automatic int m_phase();
        return (m_mode == M_RUN) ? (m_cyc - m_start) % m_ratio : 0;
    endfunction

    always @(posedge clk) begin : model
        bit had, acc, bad;
        had = (m_pend.size() != 0);
        acc = cif.cfg_valid && !had;
        bad = acc && (int'(cif.cfg_div) < 2);
        if (reset) begin
            m_mode  = M_IDLE;
            m_ratio = 7;
            m_pend.delete();
            m_err   = 1'b0;
        end else begin
            m_err = bad;
            if (m_mode == M_RUN) begin
                if (m_phase() == m_ratio - 1 && (had || !en)) m_mode = M_SW;
            end else begin
                if (had) m_ratio = m_pend.pop_front();
                if (en) begin
                    m_mode  = M_RUN;
                    m_start = m_cyc + 1;
                end else begin
                    m_mode = M_IDLE;
                end
            end
            if (acc && !bad) m_pend.push_back(int'(cif.cfg_div));
        end
        m_cyc++;
    end

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; cif.cfg_valid = 1'b0; cif.cfg_div = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({div_rst, tick, cif.cfg_ready, cif.cfg_err, busy} !== 5'b10100) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 10100 (rst,tick,ready,err,busy)",
                     {div_rst, tick, cif.cfg_ready, cif.cfg_err, busy});
        end
        n_checks++;
        if (div_val !== 8'd7 || phase !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_vals: got div_val=%0d phase=%0d expected 7/0", div_val, phase);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (div_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_hold: got div_rst=%b expected 1", div_rst);
        end
    endtask

    task automatic test_run7();
        en = 1'b1;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            n_checks++;
            if (div_rst !== 1'b0 || phase !== 8'(k % 7) || tick !== (k % 7 == 0)) begin
                n_fail++;
                $display("FAIL run7 k=%0d: got rst=%b phase=%0d tick=%b expected 0/%0d/%b",
                         k, div_rst, phase, tick, k % 7, (k % 7 == 0));
            end
        end
    endtask

    task automatic test_ratio_change();
        for (int i = 0; i < 20 && phase !== 8'd2; i++) @(negedge clk);
        n_checks++;
        if (phase !== 8'd2) begin
            n_fail++;
            $display("FAIL chg_wait: got phase=%0d expected 2", phase);
        end
        cif.cfg_valid = 1'b1; cif.cfg_div = 8'd5;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            n_checks++;
            if (t <= 4) begin
                if (div_rst !== 1'b0 || cif.cfg_ready !== 1'b0 || busy !== 1'b1 ||
                    div_val !== 8'd7 || phase !== 8'(2 + t)) begin
                    n_fail++;
                    $display("FAIL chg_pend t=%0d: got rst=%b ready=%b busy=%b div=%0d phase=%0d expected 0/0/1/7/%0d",
                             t, div_rst, cif.cfg_ready, busy, div_val, phase, 2 + t);
                end
            end else if (t == 5) begin
                if (div_rst !== 1'b1 || phase !== 8'd0 || tick !== 1'b0) begin
                    n_fail++;
                    $display("FAIL chg_switch: got rst=%b phase=%0d tick=%b expected 1/0/0",
                             div_rst, phase, tick);
                end
            end else begin
                if (div_rst !== 1'b0 || div_val !== 8'd5 || cif.cfg_ready !== 1'b1 ||
                    phase !== 8'((t - 6) % 5) || tick !== ((t - 6) % 5 == 0)) begin
                    n_fail++;
                    $display("FAIL chg_run5 t=%0d: got rst=%b div=%0d ready=%b phase=%0d tick=%b expected 0/5/1/%0d/%b",
                             t, div_rst, div_val, cif.cfg_ready, phase, tick, (t - 6) % 5, ((t - 6) % 5 == 0));
                end
            end
            cif.cfg_valid = 1'b0;
        end
    endtask

    task automatic test_bad_req();
        cif.cfg_valid = 1'b1; cif.cfg_div = 8'd1;
        @(negedge clk);
        n_checks++;
        if (cif.cfg_err !== 1'b1 || busy !== 1'b0 || cif.cfg_ready !== 1'b1 || div_val !== 8'd5) begin
            n_fail++;
            $display("FAIL bad_pulse: got err=%b busy=%b ready=%b div=%0d expected 1/0/1/5",
                     cif.cfg_err, busy, cif.cfg_ready, div_val);
        end
        cif.cfg_valid = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            n_checks++;
            if (cif.cfg_err !== 1'b0 || div_val !== 8'd5 || div_rst !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_after t=%0d: got err=%b div=%0d rst=%b busy=%b expected 0/5/0/0",
                         t, cif.cfg_err, div_val, div_rst, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10 && phase !== 8'd1; i++) @(negedge clk);
        cif.cfg_valid = 1'b1; cif.cfg_div = 8'd9;
        @(negedge clk);
        cif.cfg_valid = 1'b0;
        for (int i = 0; i < 10 && phase !== 8'd4; i++) @(negedge clk);
        n_checks++;
        if (phase !== 8'd4 || cif.cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_setup: got phase=%0d ready=%b expected 4/0", phase, cif.cfg_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (div_rst !== 1'b1 || div_val !== 8'd7 || cif.cfg_ready !== 1'b1 ||
            phase !== 8'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_state: got rst=%b div=%0d ready=%b phase=%0d busy=%b expected 1/7/1/0/0",
                     div_rst, div_val, cif.cfg_ready, phase, busy);
        end
        reset = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            n_checks++;
            if (div_rst !== 1'b0 || div_val !== 8'd7 || phase !== 8'(k % 7)) begin
                n_fail++;
                $display("FAIL rmid_run k=%0d: got rst=%b div=%0d phase=%0d expected 0/7/%0d",
                         k, div_rst, div_val, phase, k % 7);
            end
        end
    endtask

    task automatic test_disable();
        for (int i = 0; i < 10 && phase !== 8'd3; i++) @(negedge clk);
        n_checks++;
        if (phase !== 8'd3) begin
            n_fail++;
            $display("FAIL dis_wait: got phase=%0d expected 3", phase);
        end
        en = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            n_checks++;
            if (t <= 3) begin
                if (div_rst !== 1'b0 || busy !== 1'b1 || phase !== 8'(3 + t)) begin
                    n_fail++;
                    $display("FAIL dis_drain t=%0d: got rst=%b busy=%b phase=%0d expected 0/1/%0d",
                             t, div_rst, busy, phase, 3 + t);
                end
            end else begin
                if (div_rst !== 1'b1 || busy !== 1'b0 || phase !== 8'd0 || tick !== 1'b0) begin
                    n_fail++;
                    $display("FAIL dis_park t=%0d: got rst=%b busy=%b phase=%0d tick=%b expected 1/0/0/0",
                             t, div_rst, busy, phase, tick);
                end
            end
        end
    endtask

    task automatic test_idle_load();
        cif.cfg_valid = 1'b1; cif.cfg_div = 8'd9;
        @(negedge clk);
        n_checks++;
        if (cif.cfg_ready !== 1'b0 || busy !== 1'b1 || div_val !== 8'd7) begin
            n_fail++;
            $display("FAIL idle_pend: got ready=%b busy=%b div=%0d expected 0/1/7",
                     cif.cfg_ready, busy, div_val);
        end
        cif.cfg_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (div_val !== 8'd9 || cif.cfg_ready !== 1'b1 || busy !== 1'b0 || div_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_load: got div=%0d ready=%b busy=%b rst=%b expected 9/1/0/1",
                     div_val, cif.cfg_ready, busy, div_rst);
        end
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_checks++;
            if (phase !== 8'(k % 9) || tick !== (k % 9 == 0) || div_rst !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_run9 k=%0d: got phase=%0d tick=%b rst=%b expected %0d/%b/0",
                         k, phase, tick, div_rst, k % 9, (k % 9 == 0));
            end
        end
    endtask

    task automatic test_max_ratio();
        cif.cfg_valid = 1'b1; cif.cfg_div = 8'd255;
        @(negedge clk);
        cif.cfg_valid = 1'b0;
        for (int i = 0; i < 25 && div_rst !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (div_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL max_wait: got div_rst=%b expected 1 within 25 cycles", div_rst);
        end
        for (int k = 0; k < 258; k++) begin
            @(negedge clk);
            n_checks++;
            if (div_val !== 8'd255 || phase !== 8'(k % 255) || tick !== (k % 255 == 0)) begin
                n_fail++;
                $display("FAIL max_run k=%0d: got div=%0d phase=%0d tick=%b expected 255/%0d/%b",
                         k, div_val, phase, tick, k % 255, (k % 255 == 0));
            end
        end
    endtask

    task automatic test_random(input int n);
        int r;
        logic [4:0]       exp_ctrl;
        logic [DIV_W-1:0] exp_div, exp_ph;
        bit               run;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            run      = (m_mode == M_RUN);
            exp_ph   = 8'(m_phase());
            exp_div  = 8'(m_ratio);
            exp_ctrl = {!run, run && (m_phase() == 0), m_pend.size() == 0, m_err,
                        (m_pend.size() != 0) || (run && !en)};
            n_checks++;
            if ({div_rst, tick, cif.cfg_ready, cif.cfg_err, busy} !== exp_ctrl) begin
                n_fail++;
                $display("FAIL rand_ctrl i=%0d: got %b expected %b (rst,tick,ready,err,busy)",
                         i, {div_rst, tick, cif.cfg_ready, cif.cfg_err, busy}, exp_ctrl);
            end
            n_checks++;
            if (div_val !== exp_div || phase !== exp_ph) begin
                n_fail++;
                $display("FAIL rand_data i=%0d: got div=%0d phase=%0d expected %0d/%0d",
                         i, div_val, phase, exp_div, exp_ph);
            end
            reset = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            cif.cfg_valid = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 99));
            if (r < 6)       cif.cfg_div = 8'd0;
            else if (r < 12) cif.cfg_div = 8'd1;
            else if (r < 13) cif.cfg_div = 8'd255;
            else if (r < 25) cif.cfg_div = 8'd2;
            else             cif.cfg_div = 8'($urandom_range(3, 12));
        end
        reset = 1'b0;
        cif.cfg_valid = 1'b0;
    endtask

    initial begin
        cif.cfg_valid = 1'b0;
        cif.cfg_div   = '0;
        test_reset();
        test_run7();
        test_ratio_change();
        test_bad_req();
        test_reset_mid();
        test_disable();
        test_idle_load();
        test_max_ratio();
        test_random(4000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
